alu_seq: RTL and testbench

Multi-cycle sequencer that owns the 16-bit Hack-style ALU and issues operations to it on behalf of the CPU datapath. It performs either a single pass-through ALU operation or a 16×16 shift-add multiply (low 16 bits) built from repeated ALU add cycles. It sits between the instruction decode/control logic and one combinational ALU instance at the same hierarchy level, and captures results and flags into registers.

---
 rtl/alu_seq_pkg.sv | 31 +++
 rtl/alu_seq_if.sv | 32 +++
 rtl/alu_seq.sv | 163 ++++++++++++++++
 tb/tb_alu_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the ALU sequencer: FSM state encoding, operation
// encoding, ALU control-word bit positions and the two fixed control words
// the sequencer drives on its own behalf.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SINGLE,
        ST_MUL_ADD,
        ST_MUL_SHIFT,
        ST_DONE
    } state_t;

    localparam int CTRL_W = 6;

    localparam logic OP_SINGLE = 1'b0;
    localparam logic OP_MUL    = 1'b1;

    // Bit positions inside the {zx,nx,zy,ny,f,no} control word
    localparam int CTRL_ZX = 5;
    localparam int CTRL_NX = 4;
    localparam int CTRL_ZY = 3;
    localparam int CTRL_NY = 2;
    localparam int CTRL_F  = 1;
    localparam int CTRL_NO = 0;

    localparam logic [CTRL_W-1:0] CTRL_ADD  = 6'b000010;
    localparam logic [CTRL_W-1:0] CTRL_ZERO = 6'b000000;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if
// Request/response bus between the CPU control logic (master) and the ALU
// sequencer (slave).
//   start, op, ctrl_in, a_in, b_in : request, master -> slave
//   ready, done                    : handshake status, slave -> master
//   result, zr, ng                 : registered result and flags, slave -> master
interface alu_seq_if
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
);
    logic              start;
    logic              op;
    logic [CTRL_W-1:0] ctrl_in;
    logic [WIDTH-1:0]  a_in;
    logic [WIDTH-1:0]  b_in;
    logic              ready;
    logic              done;
    logic [WIDTH-1:0]  result;
    logic              zr;
    logic              ng;

    modport master (
        output start, op, ctrl_in, a_in, b_in,
        input  ready, done, result, zr, ng
    );

    modport slave (
        input  start, op, ctrl_in, a_in, b_in,
        output ready, done, result, zr, ng
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq
// Multi-cycle sequencer that drives an external combinational Hack-style ALU.
// Runs either one pass-through ALU operation (SINGLE) or a shift-add multiply
// returning the low WIDTH bits (MUL), built purely from ALU add cycles.
// Ports:
//   clk, rst_n         : clock (rising edge), async active-low reset
//   bus (slave)        : start/op/ctrl_in/a_in/b_in in; ready/done/result/zr/ng out
//   alu_x, alu_y       : operands presented to the ALU
//   alu_ctrl           : ALU control word {zx,nx,zy,ny,f,no}
//   alu_out            : ALU combinational result, used in the same cycle
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_seq_if.slave          bus,
    output logic [WIDTH-1:0]  alu_x,
    output logic [WIDTH-1:0]  alu_y,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_out
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t            state_q, state_d;

    // opa holds the multiplicand and is doubled in place on every shift cycle;
    // opb holds the multiplier, scanned LSB first by idx.
    logic [WIDTH-1:0]  opa, opb, acc;
    logic [CTRL_W-1:0] ctrl_q;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_inc;

    logic [WIDTH-1:0]  result_q;
    logic              zr_q, ng_q;

    logic              accept;
    logic              res_load;
    logic [WIDTH-1:0]  res_val;

    assign idx_inc = idx + IDX_W'(1);

    assign bus.ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.result = result_q;
    assign bus.zr     = zr_q;
    assign bus.ng     = ng_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, ALU drive and result capture selection. The ALU is held at
    // all-zero whenever the sequencer is not using it.
    always_comb begin
        state_d  = state_q;
        alu_x    = '0;
        alu_y    = '0;
        alu_ctrl = CTRL_ZERO;
        accept   = 1'b0;
        res_load = 1'b0;
        res_val  = '0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    accept = 1'b1;
                    if (bus.op == OP_MUL) begin
                        state_d = bus.b_in[0] ? ST_MUL_ADD : ST_MUL_SHIFT;
                    end else begin
                        state_d = ST_SINGLE;
                    end
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SINGLE: begin
                alu_x    = opa;
                alu_y    = opb;
                alu_ctrl = ctrl_q;
                res_load = 1'b1;
                res_val  = alu_out;
                state_d  = ST_DONE;
            end
            ST_MUL_ADD: begin
                alu_x    = opa;
                alu_y    = acc;
                alu_ctrl = CTRL_ADD;
                if (idx == LAST_IDX) begin
                    res_load = 1'b1;
                    res_val  = alu_out;
                    state_d  = ST_DONE;
                end else begin
                    state_d  = ST_MUL_SHIFT;
                end
            end
            ST_MUL_SHIFT: begin
                // Doubling via x+x keeps every arithmetic step inside the ALU.
                alu_x    = opa;
                alu_y    = opa;
                alu_ctrl = CTRL_ADD;
                if (opb[idx_inc]) begin
                    state_d  = ST_MUL_ADD;
                end else if (idx_inc == LAST_IDX) begin
                    res_load = 1'b1;
                    res_val  = acc;
                    state_d  = ST_DONE;
                end else begin
                    state_d  = ST_MUL_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operand latching, multiply datapath, and result/flag capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            ctrl_q   <= CTRL_ZERO;
            idx      <= '0;
            result_q <= '0;
            zr_q     <= 1'b0;
            ng_q     <= 1'b0;
        end else begin
            if (accept) begin
                opa    <= bus.a_in;
                opb    <= bus.b_in;
                ctrl_q <= bus.ctrl_in;
                acc    <= '0;
                idx    <= '0;
            end else begin
                case (state_q)
                    ST_MUL_ADD: begin
                        acc <= alu_out;
                    end
                    ST_MUL_SHIFT: begin
                        opa <= alu_out;
                        idx <= idx_inc;
                    end
                    default: begin
                    end
                endcase
            end
            if (res_load) begin
                result_q <= res_val;
                zr_q     <= (res_val == '0);
                ng_q     <= res_val[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq
// Self-checking bench for alu_seq. Acts as the parent that owns the
// combinational Hack ALU, keeps a transaction-level model of what the
// sequencer must report (result = ALU(a,b,ctrl) or a*b mod 2^16, latency
// 1 or popcount(b)+15 cycles), compares the DUT to it every cycle, and pins
// the model with hand-computed directed results and latencies.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  alu_x, alu_y, alu_out;
    logic [5:0]    alu_ctrl;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int c0 = 0;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .alu_x    (alu_x),
        .alu_y    (alu_y),
        .alu_ctrl (alu_ctrl),
        .alu_out  (alu_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference Hack ALU: {zx,nx,zy,ny,f,no}
    function automatic logic [W-1:0] hack_alu(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic [5:0] c);
        logic [W-1:0] xx, yy, o;
        xx = c[5] ? '0 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? '0 : y;
        if (c[2]) yy = ~yy;
        o = c[1] ? (xx + yy) : (xx & yy);
        if (c[0]) o = ~o;
        return o;
    endfunction

    assign alu_out = hack_alu(alu_x, alu_y, alu_ctrl);

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model
    logic          m_busy, m_done, m_mul, m_zr, m_ng;
    logic [W-1:0]  m_result, m_pend, m_a, m_b;
    logic [5:0]    m_c;
    int            m_rem;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_mul    <= 1'b0;
            m_rem    <= 0;
            m_result <= '0;
            m_zr     <= 1'b0;
            m_ng     <= 1'b0;
            m_pend   <= '0;
            m_a      <= '0;
            m_b      <= '0;
            m_c      <= '0;
        end else if (m_busy) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_busy   <= 1'b0;
                m_done   <= 1'b1;
                m_result <= m_pend;
                m_zr     <= (m_pend == '0);
                m_ng     <= m_pend[W-1];
            end
        end else begin
            m_done <= 1'b0;
            if (bus.start) begin
                m_busy <= 1'b1;
                m_mul  <= bus.op;
                m_a    <= bus.a_in;
                m_b    <= bus.b_in;
                m_c    <= bus.ctrl_in;
                if (bus.op) begin
                    m_rem  <= $countones(bus.b_in) + 15;
                    m_pend <= W'(bus.a_in * bus.b_in);
                end else begin
                    m_rem  <= 1;
                    m_pend <= hack_alu(bus.a_in, bus.b_in, bus.ctrl_in);
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            check_val("ready", bus.ready, !m_busy);
            check_val("done", bus.done, m_done);
            check_val("result", bus.result, m_result);
            check_val("zr", bus.zr, m_zr);
            check_val("ng", bus.ng, m_ng);
            if (!m_busy) begin
                check_val("alu_x_idle", alu_x, 0);
                check_val("alu_y_idle", alu_y, 0);
                check_val("alu_ctrl_idle", alu_ctrl, 0);
            end else if (m_mul) begin
                check_val("alu_ctrl_mul", alu_ctrl, CTRL_ADD);
            end else begin
                check_val("alu_x_single", alu_x, m_a);
                check_val("alu_y_single", alu_y, m_b);
                check_val("alu_ctrl_single", alu_ctrl, m_c);
            end
        end
    end

    // Called at a negedge: present a request for one cycle.
    task automatic apply_stimulus(input logic op, input logic [5:0] ctrl,
                                  input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.ctrl_in = ctrl;
        bus.a_in    = a;
        bus.b_in    = b;
        c0 = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Wait (bounded) for done, then pin latency and result to literals.
    task automatic check_output(input string name, input logic [W-1:0] exp_res,
                                input logic exp_zr, input logic exp_ng, input int exp_k);
        int k;
        k = cyc - c0;
        while (bus.done !== 1'b1 && k < 100) begin
            @(negedge clk);
            k = cyc - c0;
        end
        check_val({name, "_done_seen"}, bus.done, 1'b1);
        check_val({name, "_latency"}, k, exp_k);
        check_val({name, "_result"}, bus.result, exp_res);
        check_val({name, "_zr"}, bus.zr, exp_zr);
        check_val({name, "_ng"}, bus.ng, exp_ng);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.start   = 1'b0;
        bus.op      = 1'b0;
        bus.ctrl_in = '0;
        bus.a_in    = '0;
        bus.b_in    = '0;

        #3;
        check_val("rst_ready", bus.ready, 1'b1);
        check_val("rst_done", bus.done, 1'b0);
        check_val("rst_result", bus.result, 0);
        check_val("rst_alu_ctrl", alu_ctrl, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_ready", bus.ready, 1'b1);
        check_val("post_rst_done", bus.done, 1'b0);

        apply_stimulus(OP_SINGLE, 6'b000010, 16'd5, 16'd7);
        check_output("single_add", 16'h000C, 1'b0, 1'b0, 2);
        repeat (2) @(negedge clk);

        apply_stimulus(OP_SINGLE, 6'b010011, 16'd5, 16'd7);
        check_output("single_sub", 16'hFFFE, 1'b0, 1'b1, 2);
        repeat (2) @(negedge clk);

        // MUL 3x5 with a start pulse while busy that must be ignored
        apply_stimulus(OP_MUL, 6'b000000, 16'd3, 16'd5);
        repeat (3) @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = OP_SINGLE;
        bus.ctrl_in = CTRL_ADD;
        bus.a_in    = 16'h1111;
        bus.b_in    = 16'h2222;
        @(negedge clk);
        bus.start = 1'b0;
        check_output("mul_3x5", 16'h000F, 1'b0, 1'b0, 18);

        // Back-to-back: accepted in the DONE cycle
        apply_stimulus(OP_SINGLE, CTRL_ADD, 16'h0100, 16'h0023);
        check_output("b2b_single", 16'h0123, 1'b0, 1'b0, 2);
        repeat (2) @(negedge clk);

        apply_stimulus(OP_MUL, 6'b000000, 16'h1234, 16'h0000);
        check_output("mul_by_zero", 16'h0000, 1'b1, 1'b0, 16);
        repeat (2) @(negedge clk);

        apply_stimulus(OP_MUL, 6'b000000, 16'hFFFF, 16'hFFFF);
        check_output("mul_ffff", 16'h0001, 1'b0, 1'b0, 32);
        repeat (2) @(negedge clk);

        // Reset in the middle of a multiply
        apply_stimulus(OP_MUL, 6'b000000, 16'h00FF, 16'h00FF);
        while ((cyc - c0) < 10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst_ready", bus.ready, 1'b1);
        check_val("midrst_done", bus.done, 1'b0);
        check_val("midrst_result", bus.result, 0);
        check_val("midrst_zr", bus.zr, 1'b0);
        check_val("midrst_ng", bus.ng, 1'b0);
        check_val("midrst_alu_x", alu_x, 0);
        check_val("midrst_alu_y", alu_y, 0);
        check_val("midrst_alu_ctrl", alu_ctrl, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        apply_stimulus(OP_MUL, 6'b000000, 16'd7, 16'd9);
        check_output("mul_7x9", 16'h003F, 1'b0, 1'b0, 18);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
